// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one word-addressed main memory between the instruction cache
// (whole-line fills, one word per beat) and the data cache (single word
// read or write).  When both caches ask in the same IDLE cycle the side that
// did not win the previous tie gets the memory.  Every completed beat is
// followed by a one-cycle gap with both strobes low so the memory sees each
// beat as a fresh request.  The winner is released with a one-cycle ACK.
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   d_read / d_write           dcache word request (level, held until ACK)
//   d_address, d_writedata     dcache word address and write word
//   d_readdata, d_busywait     word returned to dcache, dcache stall
//   i_read, i_address          icache line-fill request and line address
//   i_readdata, i_busywait     assembled line (word k at [k*DATA_W +: DATA_W]),
//                              icache stall
//   mem_read, mem_write        memory strobes
//   mem_address, mem_writedata memory word address and write word
//   mem_readdata, mem_busywait memory read word and memory stall
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int MEM_AW    = 8,
    parameter int DATA_W    = 32,
    parameter int LINE_LOG2 = 2
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              d_read,
    input  logic                              d_write,
    input  logic [MEM_AW-1:0]                 d_address,
    input  logic [DATA_W-1:0]                 d_writedata,
    output logic [DATA_W-1:0]                 d_readdata,
    output logic                              d_busywait,
    input  logic                              i_read,
    input  logic [MEM_AW-LINE_LOG2-1:0]       i_address,
    output logic [(DATA_W<<LINE_LOG2)-1:0]    i_readdata,
    output logic                              i_busywait,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [MEM_AW-1:0]                 mem_address,
    output logic [DATA_W-1:0]                 mem_writedata,
    input  logic [DATA_W-1:0]                 mem_readdata,
    input  logic                              mem_busywait
);

    typedef enum logic [2:0] {IDLE, D_XFER, I_XFER, GAP, ACK} state_t;
    typedef enum logic {OWNER_D, OWNER_I} owner_t;

    localparam logic [LINE_LOG2-1:0] LAST_BEAT = '1;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                last_grant_q, last_grant_d;
    logic [LINE_LOG2-1:0]  beat_q, beat_d;
    logic [MEM_AW-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  beat_done;
    logic                  d_req;

    assign d_req = d_read | d_write;

    // Stalls follow the request combinationally; only the ACK cycle of the
    // owning side releases it.
    assign d_busywait = d_req  && !(state_q == ACK && owner_q == OWNER_D);
    assign i_busywait = i_read && !(state_q == ACK && owner_q == OWNER_I);

    // Next-state and memory-side outputs.  Address and write word fall back
    // to the held copies outside the transfer states.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        beat_d        = beat_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = addr_q;
        mem_writedata = wdata_q;
        beat_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && i_read) begin
                    // Tie: the side that lost the previous tie wins now.
                    if (last_grant_q == OWNER_I) begin
                        owner_d      = OWNER_D;
                        last_grant_d = OWNER_D;
                        state_d      = D_XFER;
                    end else begin
                        owner_d      = OWNER_I;
                        last_grant_d = OWNER_I;
                        beat_d       = '0;
                        state_d      = I_XFER;
                    end
                end else if (d_req) begin
                    owner_d = OWNER_D;
                    state_d = D_XFER;
                end else if (i_read) begin
                    owner_d = OWNER_I;
                    beat_d  = '0;
                    state_d = I_XFER;
                end
            end
            D_XFER: begin
                mem_read      = d_read;
                mem_write     = d_write;
                mem_address   = d_address;
                mem_writedata = d_writedata;
                if (d_req && !mem_busywait) begin
                    beat_done = 1'b1;
                    state_d   = GAP;
                end
            end
            I_XFER: begin
                mem_read    = 1'b1;
                mem_address = {i_address, beat_q};
                if (!mem_busywait) begin
                    beat_done = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (owner_q == OWNER_I && beat_q != LAST_BEAT) begin
                    beat_d  = beat_q + 1'b1;
                    state_d = I_XFER;
                end else begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, held memory-side values and read-data capture.  A reset aborts
    // any transfer and clears the partially assembled line.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_D;
            last_grant_q <= OWNER_I;
            beat_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            d_readdata   <= '0;
            i_readdata   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            if (state_q == D_XFER || state_q == I_XFER) begin
                addr_q  <= mem_address;
                wdata_q <= mem_writedata;
            end
            if (beat_done) begin
                if (owner_q == OWNER_I) begin
                    i_readdata[beat_q*DATA_W +: DATA_W] <= mem_readdata;
                end else if (d_read) begin
                    d_readdata <= mem_readdata;
                end
            end
        end
    end

endmodule
